bsg_fifo_1r1w_tracked_sync_read: RTL and testbench

// - Valid/ready 1-read/1-write FIFO built around a wptr/rptr/rptr_n pointer tracker and a
//   1r1w synchronous-read storage array.
// - The array is read at the next read pointer (rptr_n), so the head entry sits registered
//   on data_o in the cycle the tracker reports non-empty. No combinational path from

---
 rtl/bsg_fifo_1r1w_tracked_sync_read_if.sv | 19 +
 rtl/bsg_fifo_1r1w_tracked_sync_read.sv | 129 ++++++++++++
 tb/tb_bsg_fifo_1r1w_tracked_sync_read.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/bsg_fifo_1r1w_tracked_sync_read_if.sv
// Handshake bundle for bsg_fifo_1r1w_tracked_sync_read.
// Signal names are from the FIFO's point of view (_i = into the FIFO, _o = out of it).
//   v_i/data_i/ready_o : ready-then-valid producer side
//   v_o/data_o/yumi_i  : valid-then-yumi consumer side
// slave  : the FIFO itself
// master : the environment that drives the producer and consumer sides
interface bsg_fifo_1r1w_tracked_sync_read_if #(
  parameter int unsigned width_p = 32
);
  logic               v_i;
  logic [width_p-1:0] data_i;
  logic               ready_o;
  logic               v_o;
  logic [width_p-1:0] data_o;
  logic               yumi_i;

  modport slave  (input  v_i, data_i, yumi_i, output ready_o, v_o, data_o);
  modport master (output v_i, data_i, yumi_i, input  ready_o, v_o, data_o);
endinterface

// File: rtl/bsg_fifo_1r1w_tracked_sync_read.sv
// Valid/ready 1r1w FIFO: wptr/rptr pointer tracker plus a synchronous-read array.
// The array is read at the next read pointer every cycle, so the head entry is
// already registered on data_o when v_o rises; no storage-to-output comb path.
//
// Ports:
//   clk_i    : clock, all state on posedge
//   reset_i  : synchronous active-high reset (drops all entries)
//   io       : slave modport of bsg_fifo_1r1w_tracked_sync_read_if
//              (v_i, data_i, ready_o, v_o, data_o, yumi_i)
//   count_o  : registered occupancy, only when BSG_FIFO_TRACKED_COUNT_EN is defined
//
// Optional feature macro: BSG_FIFO_TRACKED_COUNT_EN
module bsg_fifo_1r1w_tracked_sync_read #(
  parameter int unsigned width_p = 32,
  parameter int unsigned els_p   = 256
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  bsg_fifo_1r1w_tracked_sync_read_if.slave   io
`ifdef BSG_FIFO_TRACKED_COUNT_EN
  ,
  output logic [$clog2(els_p+1)-1:0]         count_o
`endif
);

  localparam int unsigned lg_els_lp = $clog2(els_p);

  logic [lg_els_lp-1:0] wptr_q, wptr_d;
  logic [lg_els_lp-1:0] rptr_q, rptr_d;   // rptr_d is the next read pointer (rptr_n)
  logic                 last_enq_q, last_enq_d;
  logic                 last_deq_q, last_deq_d;
  logic [width_p-1:0]   data_r_q, data_r_d;
  logic [width_p-1:0]   mem_q [els_p];

  logic ptr_eq, full, empty, enq, deq, bypass;

  // Tracker next state, handshake decode and read/bypass select
  always_comb begin
    ptr_eq     = (wptr_q == rptr_q);
    full       = ptr_eq & last_enq_q;
    empty      = ptr_eq & last_deq_q;
    // ready_o is ~full only, so a full FIFO refuses enq even when deq fires
    enq        = io.v_i & ~full;
    deq        = io.yumi_i;
    wptr_d     = wptr_q + lg_els_lp'(enq);
    rptr_d     = rptr_q + lg_els_lp'(deq);
    last_enq_d = last_enq_q;
    last_deq_d = last_deq_q;
    if (enq | deq) begin
      last_enq_d = enq;
      last_deq_d = deq;
    end
    // The entry being written is the one the next head read would hit: take it
    // straight from data_i so array read-during-write never matters.
    bypass     = enq & (wptr_q == rptr_d);
    data_r_d   = bypass ? io.data_i : mem_q[rptr_d];
  end

  // Tracker and head register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      last_enq_q <= 1'b0;
      last_deq_q <= 1'b1;
      data_r_q   <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      last_enq_q <= last_enq_d;
      last_deq_q <= last_deq_d;
      data_r_q   <= data_r_d;
    end
  end

  // Storage array, write port only; contents are not reset
  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem_q[wptr_q] <= io.data_i;
    end
  end

  assign io.ready_o = ~full;
  assign io.v_o     = ~empty;
  assign io.data_o  = data_r_q;

`ifdef BSG_FIFO_TRACKED_COUNT_EN
  localparam int unsigned cnt_w_lp = $clog2(els_p+1);

  logic [cnt_w_lp-1:0] count_q, count_d;

  // Occupancy: moves only when exactly one of enq/deq fires
  always_comb begin
    count_d = count_q;
    if (enq & ~deq) begin
      count_d = count_q + cnt_w_lp'(1);
    end else if (deq & ~enq) begin
      count_d = count_q - cnt_w_lp'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
`endif

`ifndef SYNTHESIS
  // Protocol and consistency checks
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(io.yumi_i && !io.v_o))
        else $error("yumi_i asserted while v_o is low");
`ifdef BSG_FIFO_TRACKED_COUNT_EN
      assert ((count_o == '0) == !io.v_o)
        else $error("count_o zero disagrees with v_o");
      assert ((count_o == cnt_w_lp'(els_p)) == !io.ready_o)
        else $error("count_o full disagrees with ready_o");
`endif
    end
  end
`endif

endmodule

// File: tb/tb_bsg_fifo_1r1w_tracked_sync_read.sv
// Self-checking bench: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_bsg_fifo_1r1w_tracked_sync_read;

  localparam int unsigned W = 8;
  localparam int unsigned N = 4;

  logic clk_i = 1'b0;
  logic reset_i;
  always #5 clk_i = ~clk_i;

  bsg_fifo_1r1w_tracked_sync_read_if #(.width_p(W)) fifo_if ();

`ifdef BSG_FIFO_TRACKED_COUNT_EN
  logic [2:0] count_o;
`endif

  bsg_fifo_1r1w_tracked_sync_read #(.width_p(W), .els_p(N)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .io      (fifo_if)
`ifdef BSG_FIFO_TRACKED_COUNT_EN
    ,
    .count_o (count_o)
`endif
  );

  int       tests = 0;
  int       fails = 0;
  logic [7:0] q[$];       // model contents, head at q[0]
  bit       zero_data;    // data_o must read 0 right after a reset edge
  bit       running = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model step for one clock edge
  task automatic model_update(input logic v, input logic [7:0] d, input logic y, input logic r);
    bit do_enq, do_deq;
    if (r) begin
      q.delete();
      zero_data = 1'b1;
    end else begin
      zero_data = 1'b0;
      do_enq = v && (q.size() < N);
      do_deq = y && (q.size() > 0);
      if (do_deq) void'(q.pop_front());
      if (do_enq) q.push_back(d);
    end
  endtask

  // One clock: drive at negedge, model follows just after posedge
  task automatic cycle(input logic v, input logic [7:0] d, input logic y, input logic r);
    @(negedge clk_i);
    fifo_if.v_i    = v;
    fifo_if.data_i = d;
    fifo_if.yumi_i = y;
    reset_i        = r;
    @(posedge clk_i);
    #2;
    model_update(v, d, y, r);
  endtask

  // Compare process: DUT outputs vs model on every negedge
  always @(negedge clk_i) begin
    if (running) begin
      chk("model_ready", fifo_if.ready_o, 32'(q.size() < N));
      chk("model_v", fifo_if.v_o, 32'(q.size() > 0));
      if (q.size() > 0) chk("model_data", fifo_if.data_o, 32'(q[0]));
      else if (zero_data) chk("model_data_reset", fifo_if.data_o, 32'h0);
`ifdef BSG_FIFO_TRACKED_COUNT_EN
      chk("model_count", count_o, 32'(q.size()));
`endif
    end
  end

  initial begin
    fifo_if.v_i    = 1'b0;
    fifo_if.data_i = '0;
    fifo_if.yumi_i = 1'b0;
    reset_i        = 1'b1;
    @(posedge clk_i);
    #2;
    model_update(1'b0, 8'h00, 1'b0, 1'b1);
    running = 1'b1;

    // Reset held two cycles
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("rst_ready", fifo_if.ready_o, 32'h1);
    chk("rst_v", fifo_if.v_o, 32'h0);
    chk("rst_data", fifo_if.data_o, 32'h0);
`ifdef BSG_FIFO_TRACKED_COUNT_EN
    chk("rst_count", count_o, 32'h0);
`endif

    // Fall-through
    cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("ft_v", fifo_if.v_o, 32'h1);
    chk("ft_data", fifo_if.data_o, 32'hA5);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("ft_empty", fifo_if.v_o, 32'h0);

    // Fill, refuse extra, drain; repeated so pointers wrap
    for (int rep = 0; rep < 3; rep++) begin
      for (int i = 1; i <= 4; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
      chk("fill_full", fifo_if.ready_o, 32'h0);
`ifdef BSG_FIFO_TRACKED_COUNT_EN
      chk("fill_count", count_o, 32'h4);
`endif
      cycle(1'b1, 8'h05, 1'b0, 1'b0);
      chk("fill_refused", fifo_if.ready_o, 32'h0);
      for (int i = 1; i <= 4; i++) begin
        chk("drain_data", fifo_if.data_o, 32'(i));
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
      end
      chk("drain_empty", fifo_if.v_o, 32'h0);
    end

    // Simultaneous enq+deq with one entry
    cycle(1'b1, 8'h10, 1'b0, 1'b0);
    cycle(1'b1, 8'h20, 1'b1, 1'b0);
    chk("sim_v", fifo_if.v_o, 32'h1);
    chk("sim_data", fifo_if.data_o, 32'h20);
    chk("sim_ready", fifo_if.ready_o, 32'h1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Full with deq: the offered word is refused
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'h55, 1'b1, 1'b0);
    chk("fd_ready", fifo_if.ready_o, 32'h1);
    for (int i = 0; i < 3; i++) begin
      chk("fd_drain", fifo_if.data_o, 32'(8'h12 + i));
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("fd_empty", fifo_if.v_o, 32'h0);

    // Reset mid-operation
    cycle(1'b1, 8'h30, 1'b0, 1'b0);
    cycle(1'b1, 8'h31, 1'b0, 1'b0);
    cycle(1'b1, 8'h32, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("mr_v", fifo_if.v_o, 32'h0);
    chk("mr_ready", fifo_if.ready_o, 32'h1);
    cycle(1'b1, 8'h77, 1'b0, 1'b0);
    chk("mr_data", fifo_if.data_o, 32'h77);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      logic       rv, ry, rr;
      logic [7:0] rd;
      rr = ($urandom_range(0, 199) == 0);
      rv = ($urandom_range(0, 2) != 0);
      ry = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      rd = 8'($urandom);
      cycle(rv, rd, ry, rr);
    end

    @(negedge clk_i);
    running = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
